// File: rtl/fp_cvt_widen_pipe_pkg.sv
// ---------------------------------------------------------------------------
// fpCvtPkg
//   Shared definitions for the IEEE-754 widening converter:
//   - fp_class_e : operand classification carried from S1 to S2
//   - fp_half_t / fp_quad_t : {sign,exp,sig} layouts for the default formats
//     (modules build the same layout locally from their own parameters)
//   - bias()     : exponent bias of a format with the given exponent width
// ---------------------------------------------------------------------------
package fpCvtPkg;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        SUB  = 3'd1,
        NORM = 3'd2,
        INF  = 3'd3,
        QNAN = 3'd4,
        SNAN = 3'd5
    } fp_class_e;

    localparam int HALF_EXP = 5;
    localparam int HALF_SIG = 10;
    localparam int QUAD_EXP = 15;
    localparam int QUAD_SIG = 112;

    typedef struct packed {
        logic                sign;
        logic [HALF_EXP-1:0] exp;
        logic [HALF_SIG-1:0] sig;
    } fp_half_t;

    typedef struct packed {
        logic                sign;
        logic [QUAD_EXP-1:0] exp;
        logic [QUAD_SIG-1:0] sig;
    } fp_quad_t;

    // Bias of a binary format: 2^(exp_w-1) - 1.
    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_cvt_widen_pipe_lzc.sv
// ---------------------------------------------------------------------------
// fp_cvt_lzc
//   Combinational leading-zero counter over a W-bit vector.
//   Ports:
//     i_vec  in   W               vector to scan (MSB = bit W-1)
//     o_cnt  out  $clog2(W+1)     number of zeros above the highest set bit;
//                                 W when the vector is all zero
// ---------------------------------------------------------------------------
module fp_cvt_lzc #(
    parameter  int W  = 10,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_vec,
    output logic [CW-1:0] o_cnt
);

    // Ascending scan: the highest set bit is the last one to write o_cnt.
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) begin
                o_cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_cvt_widen_pipe.sv
// ---------------------------------------------------------------------------
// fp_cvt_widen_pipe
//   Three-stage pipelined IEEE-754 widening converter (default half -> quad).
//   The conversion is exact. Subnormals are normalised (or flushed to signed
//   zero when daz=1), sNaNs are quietened and flagged via out_inv.
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     in_valid/in_ready   operand handshake; in_data={sign,exp,frac}
//     in_tag              opaque tag, returned with the result
//     daz                 1 = subnormal input becomes signed zero
//     out_valid/out_ready result handshake
//     out_data            {sign,exp,frac} in the wide format
//     out_tag, out_inv    tag of out_data; 1 when the input was an sNaN
//
//   Handshake: a transfer happens on a rising edge where valid & ready are
//   both 1. valid never depends on ready; ready may depend on valid
//   (combinational ready chain from out_ready back to in_ready). A stage
//   loads when it is empty or its content leaves in the same cycle;
//   otherwise it holds its data.
//
//   Stages: S1 classify + LZC, S2 shift fraction / compute exponent,
//   S3 output register.
// ---------------------------------------------------------------------------
module fp_cvt_widen_pipe
    import fpCvtPkg::*;
#(
    parameter int IN_EXP  = 5,
    parameter int IN_SIG  = 10,
    parameter int OUT_EXP = 15,
    parameter int OUT_SIG = 112,
    parameter int TAGW    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_EXP+IN_SIG:0]     in_data,
    input  logic [TAGW-1:0]            in_tag,
    input  logic                       daz,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_EXP+OUT_SIG:0]   out_data,
    output logic [TAGW-1:0]            out_tag,
    output logic                       out_inv
);

    localparam int LZW  = $clog2(IN_SIG + 1);
    localparam int PADW = OUT_SIG - IN_SIG;
    // Rebias constant BO - BI, at output exponent width.
    localparam logic [OUT_EXP-1:0] BDIFF = OUT_EXP'(bias(OUT_EXP) - bias(IN_EXP));

    typedef struct packed {
        logic              sign;
        logic [IN_EXP-1:0] exp;
        logic [IN_SIG-1:0] sig;
    } in_fp_t;

    typedef struct packed {
        logic               sign;
        logic [OUT_EXP-1:0] exp;
        logic [OUT_SIG-1:0] sig;
    } out_fp_t;

    // ---------------- handshake chain ----------------
    logic r1_valid, r2_valid, r3_valid;
    logic w_s1_go, w_s2_go, w_s3_go;

    assign w_s3_go  = ~r3_valid | out_ready;
    assign w_s2_go  = ~r2_valid | w_s3_go;
    assign w_s1_go  = ~r1_valid | w_s2_go;
    assign in_ready = w_s1_go;

    // ---------------- S1: classify + LZC ----------------
    in_fp_t          w_in;
    fp_class_e       w_cls;
    logic [LZW-1:0]  w_lz;

    assign w_in = in_data;

    always_comb begin
        if (&w_in.exp) begin
            if (w_in.sig == '0)            w_cls = INF;
            else if (w_in.sig[IN_SIG-1])   w_cls = QNAN;
            else                           w_cls = SNAN;
        end else if (w_in.exp == '0) begin
            // daz is taken together with the operand, so it is folded in here.
            if (w_in.sig == '0 || daz)     w_cls = ZERO;
            else                           w_cls = SUB;
        end else begin
            w_cls = NORM;
        end
    end

    fp_cvt_lzc #(.W(IN_SIG)) u_lzc (
        .i_vec (w_in.sig),
        .o_cnt (w_lz)
    );

    fp_class_e         r1_cls;
    logic              r1_sign;
    logic [IN_EXP-1:0] r1_exp;
    logic [IN_SIG-1:0] r1_sig;
    logic [LZW-1:0]    r1_lz;
    logic [TAGW-1:0]   r1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_cls   <= ZERO;
            r1_sign  <= 1'b0;
            r1_exp   <= '0;
            r1_sig   <= '0;
            r1_lz    <= '0;
            r1_tag   <= '0;
        end else if (w_s1_go) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_cls  <= w_cls;
                r1_sign <= w_in.sign;
                r1_exp  <= w_in.exp;
                r1_sig  <= w_in.sig;
                r1_lz   <= w_lz;
                r1_tag  <= in_tag;
            end
        end
    end

    // ---------------- S2: fraction shift + exponent ----------------
    logic [OUT_EXP-1:0] w_exp2;
    logic [IN_SIG-1:0]  w_sig2;
    logic [IN_SIG-1:0]  w_sub_sig;
    logic               w_inv2;
    out_fp_t            w_res2;

    // Shift the leading one out: it becomes the implicit bit.
    assign w_sub_sig = (r1_sig << r1_lz) << 1;

    always_comb begin
        w_exp2 = '0;
        w_sig2 = '0;
        w_inv2 = 1'b0;
        case (r1_cls)
            NORM: begin
                w_exp2 = OUT_EXP'(r1_exp) + BDIFF;
                w_sig2 = r1_sig;
            end
            SUB: begin
                w_exp2 = BDIFF - OUT_EXP'(r1_lz);
                w_sig2 = w_sub_sig;
            end
            INF: begin
                w_exp2 = '1;
            end
            QNAN, SNAN: begin
                w_exp2 = '1;
                w_sig2 = {1'b1, r1_sig[IN_SIG-2:0]};
                w_inv2 = (r1_cls == SNAN);
            end
            default: begin
                // ZERO (including daz-flushed subnormals): all-zero magnitude.
            end
        endcase
    end

    assign w_res2.sign = r1_sign;
    assign w_res2.exp  = w_exp2;
    assign w_res2.sig  = OUT_SIG'(w_sig2) << PADW;

    out_fp_t         r2_data;
    logic            r2_inv;
    logic [TAGW-1:0] r2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_data  <= '0;
            r2_inv   <= 1'b0;
            r2_tag   <= '0;
        end else if (w_s2_go) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_data <= w_res2;
                r2_inv  <= w_inv2;
                r2_tag  <= r1_tag;
            end
        end
    end

    // ---------------- S3: output register ----------------
    out_fp_t         r3_data;
    logic            r3_inv;
    logic [TAGW-1:0] r3_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid <= 1'b0;
            r3_data  <= '0;
            r3_inv   <= 1'b0;
            r3_tag   <= '0;
        end else if (w_s3_go) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_data <= r2_data;
                r3_inv  <= r2_inv;
                r3_tag  <= r2_tag;
            end
        end
    end

    assign out_valid = r3_valid;
    assign out_data  = r3_data;
    assign out_tag   = r3_tag;
    assign out_inv   = r3_inv;

endmodule

// File: tb/tb_fp_cvt_widen_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_cvt_widen_pipe
//   Bench for the half -> quad widening converter (default parameters).
//   Expected words are {out_data, out_tag, out_inv}.
// ---------------------------------------------------------------------------
module tb_fp_cvt_widen_pipe;

    localparam int W = 128 + 4 + 1;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic [3:0]   in_tag;
    logic         daz;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_tag;
    logic         out_inv;

    always #5 clk = ~clk;

    fp_cvt_widen_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .daz       (daz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_inv   (out_inv)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           deliv_cyc[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    logic         bp_en = 1'b0;

    typedef struct {
        logic [15:0]  din;
        logic         dz;
        logic [127:0] dout;
        logic         inv;
    } vec_t;

    vec_t vecs[15];

    always @(posedge clk) cyc++;

    // Random backpressure, only while enabled.
    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model, written from the IEEE definitions: {quad, inv}.
    function automatic logic [128:0] model(input logic [15:0] d, input logic dz);
        logic        s;
        logic [4:0]  e;
        logic [9:0]  f;
        logic [10:0] m;
        int          ex;
        s = d[15];
        e = d[14:10];
        f = d[9:0];
        if (e == 5'h1F) begin
            if (f == 10'h0) return {s, 15'h7FFF, 112'h0, 1'b0};
            return {s, 15'h7FFF, 1'b1, f[8:0], 102'h0, ~f[9]};
        end
        if (e == 5'h0) begin
            if (f == 10'h0 || dz) return {s, 128'h0};
            m  = {1'b0, f};
            ex = -14;
            while (!m[10]) begin
                m  = m << 1;
                ex = ex - 1;
            end
            return {s, 15'(ex + 16383), m[9:0], 102'h0, 1'b0};
        end
        return {s, 15'(int'(e) - 15 + 16383), f, 102'h0, 1'b0};
    endfunction

    function automatic logic [W-1:0] pack(input logic [128:0] m, input logic [3:0] tg);
        return {m[128:1], tg, m[0]};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            deliv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got %h, required none", {out_data, out_tag, out_inv});
            end else begin
                check("result", {out_data, out_tag, out_inv}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] d, input logic dz, input logic [3:0] tg,
                        input logic [128:0] m, output int stalls);
        in_valid = 1'b1;
        in_data  = d;
        daz      = dz;
        in_tag   = tg;
        stalls   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(pack(m, tg));
                break;
            end
            stalls++;
            if (stalls > 100) begin
                check("send_timeout", W'(stalls), W'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, W'(exp_q.size()), W'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int           st;
        int           tot;
        int           acc;
        int           seen;
        logic [2:0]   lat;
        logic [15:0]  d;
        logic         dz;
        logic         ov;

        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_tag    = 4'h0;
        daz       = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        vecs[0]  = '{16'h3C00, 1'b0, {32'h3FFF0000, 96'h0}, 1'b0};
        vecs[1]  = '{16'h0001, 1'b0, {32'h3FE70000, 96'h0}, 1'b0};
        vecs[2]  = '{16'h0001, 1'b1, 128'h0,                1'b0};
        vecs[3]  = '{16'h8001, 1'b1, {32'h80000000, 96'h0}, 1'b0};
        vecs[4]  = '{16'h7D00, 1'b0, {32'h7FFFC000, 96'h0}, 1'b1};
        vecs[5]  = '{16'h7E00, 1'b0, {32'h7FFF8000, 96'h0}, 1'b0};
        vecs[6]  = '{16'hFC00, 1'b0, {32'hFFFF0000, 96'h0}, 1'b0};
        vecs[7]  = '{16'h0000, 1'b0, 128'h0,                1'b0};
        vecs[8]  = '{16'h8000, 1'b0, {32'h80000000, 96'h0}, 1'b0};
        vecs[9]  = '{16'h03FF, 1'b0, {32'h3FF0FF80, 96'h0}, 1'b0};
        vecs[10] = '{16'h0200, 1'b0, {32'h3FF00000, 96'h0}, 1'b0};
        vecs[11] = '{16'h0400, 1'b0, {32'h3FF10000, 96'h0}, 1'b0};
        vecs[12] = '{16'h7BFF, 1'b0, {32'h400EFFC0, 96'h0}, 1'b0};
        vecs[13] = '{16'h7C01, 1'b0, {32'h7FFF8040, 96'h0}, 1'b1};
        vecs[14] = '{16'h7C00, 1'b1, {32'h7FFF0000, 96'h0}, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", W'(out_data), W'(0));
        check("rst_tag_inv", W'({out_tag, out_inv}), W'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        // Latency: handshake cycle is cycle 0, out_valid must rise in cycle 3.
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        daz      = 1'b0;
        in_tag   = 4'hA;
        @(negedge clk);
        check("lat_in_ready", W'(in_ready), W'(1));
        if (in_ready) exp_q.push_back(pack(model(16'h3C00, 1'b0), 4'hA));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk) lat[2] = out_valid;
        @(negedge clk) lat[1] = out_valid;
        @(negedge clk) lat[0] = out_valid;
        check("latency", W'(lat), W'(3'b001));
        drain("lat_drain");

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].din, vecs[i].dz, 4'(i), {vecs[i].dout, vecs[i].inv}, st);
        end
        drain("table_drain");

        // Back-to-back stream of 8, tags 0..7.
        @(posedge clk);
        #1;
        deliv_cyc.delete();
        tot = 0;
        for (int t = 0; t < 8; t++) begin
            d = 16'(16'h3800 + t * 16'h0111);
            send(d, 1'b0, 4'(t), model(d, 1'b0), st);
            tot += st;
        end
        check("stream_in_ready_low", W'(tot), W'(0));
        drain("stream_drain");
        check("stream_count", W'(deliv_cyc.size()), W'(8));
        if (deliv_cyc.size() == 8) begin
            check("stream_rate", W'(deliv_cyc[7] - deliv_cyc[0]), W'(7));
        end

        // Stall: out_ready low for 6 cycles with in_valid held high.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        in_data  = 16'h4000;
        daz      = 1'b0;
        in_tag   = 4'h8;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(pack(model(in_data, 1'b0), in_tag));
                acc++;
            end
            @(posedge clk);
            #1;
            in_data = 16'h4000 + 16'(acc) * 16'h0123;
            in_tag  = 4'(8 + acc);
        end
        check("stall_accepts", W'(acc), W'(3));
        @(negedge clk);
        check("stall_in_ready", W'(in_ready), W'(0));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("stall_drain");

        // Random operands under random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            d  = 16'($urandom_range(0, 65535));
            dz = 1'($urandom_range(0, 1));
            send(d, dz, 4'(i), model(d, dz), st);
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain("random_drain");

        // Reset with two operands in flight.
        out_ready = 1'b0;
        send(16'h3C00, 1'b0, 4'h1, model(16'h3C00, 1'b0), st);
        send(16'hC000, 1'b0, 4'h2, model(16'hC000, 1'b0), st);
        ov = 1'b0;
        for (int c = 0; c < 10 && !ov; c++) begin
            @(negedge clk);
            ov = out_valid;
        end
        check("rst_pre_valid", W'(ov), W'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", W'(out_valid), W'(0));
        check("rst_async_data", W'(out_data), W'(0));
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", W'(in_ready), W'(1));
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_stale", W'(seen), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
